// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with tag passthrough and a valid/ready stall.
// Optional macro SHIFTER_OVERFLOW_EN adds out_ovf, the signed-overflow flag for SLL.
module pipelined_barrel_shifter #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned REG_EVERY = 2,
   parameter int unsigned TAG_W     = 5
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(WIDTH)-1:0] in_shamt,
   input  logic [1:0]               in_op,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
`ifdef SHIFTER_OVERFLOW_EN
   output logic                     out_ovf,
`endif
   output logic [TAG_W-1:0]         out_tag
);

   localparam int unsigned LEVELS = $clog2(WIDTH);
   localparam int unsigned STAGES = (LEVELS + REG_EVERY - 1) / REG_EVERY;
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [1:0]        op;
      logic              sign;
`ifdef SHIFTER_OVERFLOW_EN
      logic              ovf;
`endif
      logic [LEVELS-1:0] shamt;
      logic [TAG_W-1:0]  tag;
      logic [WIDTH-1:0]  data;
   } stage_t;

   stage_t                in_s;
   stage_t [LEVELS-1:0]   lv;
   stage_t [STAGES-1:0]   stg_q;
   stage_t                tail;
   logic                  advance;
   logic                  unused_tail;

   // A stalled output freezes the whole pipe; a free or empty output lets every stage move.
   assign tail      = stg_q[STAGES-1];
   assign advance   = out_ready | ~tail.valid;
   assign in_ready  = advance;
   assign out_valid = tail.valid;
   assign out_data  = tail.data;
   assign out_tag   = tail.tag;
`ifdef SHIFTER_OVERFLOW_EN
   assign out_ovf   = tail.ovf;
`endif
   assign unused_tail = ^{tail.op, tail.sign, tail.shamt};

   // The SRA fill bit is captured once here and travels with the operand.
   always_comb begin
      in_s       = '0;
      in_s.valid = in_valid;
      in_s.op    = in_op;
      in_s.sign  = in_data[WIDTH-1];
      in_s.shamt = in_shamt;
      in_s.tag   = in_tag;
      in_s.data  = in_data;
   end

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int unsigned B  = LEVELS - 1 - k;
      localparam int unsigned SH = 1 << B;
      stage_t cur;
      stage_t nxt;

      if (k == 0) begin : g_src_in
         assign cur = in_s;
      end else if (k % REG_EVERY == 0) begin : g_src_reg
         assign cur = stg_q[k / REG_EVERY - 1];
      end else begin : g_src_lvl
         assign cur = lv[k-1];
      end

      // One mux level: conditional shift by SH, largest amounts first.
      always_comb begin
         nxt = cur;
         if (cur.shamt[B]) begin
            case (cur.op)
               OP_SLL: begin
                  nxt.data = cur.data << SH;
`ifdef SHIFTER_OVERFLOW_EN
                  nxt.ovf  = cur.ovf
                           | (|((cur.data ^ {WIDTH{cur.sign}}) & ~(ONES >> SH)))
                           | (cur.data[WIDTH-1-SH] ^ cur.sign);
`endif
               end
               OP_SRL:  nxt.data = cur.data >> SH;
               OP_SRA:  nxt.data = (cur.data >> SH) | ({WIDTH{cur.sign}} & ~(ONES >> SH));
               default: nxt.data = (cur.data >> SH) | (cur.data << (WIDTH - SH));
            endcase
         end
      end

      assign lv[k] = nxt;
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stg
      localparam int unsigned SPAN_END = (s + 1) * REG_EVERY;
      localparam int unsigned LAST     = ((SPAN_END < LEVELS) ? SPAN_END : LEVELS) - 1;
      stage_t q;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            q <= '0;
         end else if (advance) begin
            q <= lv[LAST];
         end
      end

      assign stg_q[s] = q;
   end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: default build (32-bit, REG_EVERY=2) plus an 8-bit, REG_EVERY=1 instance.
module tb_pipelined_barrel_shifter;

   localparam int L = 3;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [4:0]  in_shamt, in_tag, out_tag;
   logic [1:0]  in_op;

   logic        r8_in_valid, r8_in_ready, r8_out_valid, r8_out_ready;
   logic [7:0]  r8_in_data, r8_out_data;
   logic [2:0]  r8_in_shamt;
   logic [1:0]  r8_in_op;
   logic [4:0]  r8_in_tag, r8_out_tag;
`ifdef SHIFTER_OVERFLOW_EN
   logic        out_ovf, r8_out_ovf;
`endif

   always #5 clock = ~clock;

   pipelined_barrel_shifter u_dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef SHIFTER_OVERFLOW_EN
      .out_ovf(out_ovf),
`endif
      .out_tag(out_tag)
   );

   pipelined_barrel_shifter #(.WIDTH(8), .REG_EVERY(1), .TAG_W(5)) u_dut8 (
      .clock(clock), .reset_n(reset_n),
      .in_valid(r8_in_valid), .in_ready(r8_in_ready), .in_data(r8_in_data),
      .in_shamt(r8_in_shamt), .in_op(r8_in_op), .in_tag(r8_in_tag),
      .out_valid(r8_out_valid), .out_ready(r8_out_ready), .out_data(r8_out_data),
`ifdef SHIFTER_OVERFLOW_EN
      .out_ovf(r8_out_ovf),
`endif
      .out_tag(r8_out_tag)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
`ifdef SHIFTER_OVERFLOW_EN
      logic        ovf;
`endif
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] got_data[$];
   logic [4:0]  got_tag[$];
`ifdef SHIFTER_OVERFLOW_EN
   logic        got_ovf[$];
`endif
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          lat_check  = 1'b0;
   bit          prev_stall = 1'b0;
   bit          saw_low;
   bit          done;
   bit          ov[9];
   logic [31:0] held_data;
   logic [4:0]  held_tag;

   logic [31:0] exp1[4] = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h1800_000F};
   logic [31:0] exp2[7] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0003};
   logic [7:0]  d8[5] = '{8'h81, 8'h80, 8'h81, 8'h81, 8'h81};
   logic [2:0]  s8[5] = '{3'd1, 3'd7, 3'd1, 3'd7, 3'd7};
   logic [1:0]  o8[5] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd3};
   logic [7:0]  x8[5] = '{8'hC0, 8'hFF, 8'h02, 8'h01, 8'h03};

   // Reference shifter on a w-bit operand held in 64 bits.
   function automatic logic [63:0] ref_shift(logic [63:0] d, int unsigned s, logic [1:0] op, int unsigned w);
      logic [63:0] m;
      logic [63:0] r;
      m = (64'h1 << w) - 64'h1;
      case (op)
         2'd0:    r = (d << s) & m;
         2'd1:    r = d >> s;
         2'd2:    r = (d >> s) | (d[w-1] ? (m & ~(m >> s)) : 64'h0);
         default: r = ((d >> s) | (d << (w - s))) & m;
      endcase
      return r;
   endfunction

   function automatic longint sext(logic [63:0] v, int unsigned w);
      longint t;
      t = longint'(v << (64 - w));
      return t >>> (64 - w);
   endfunction

   // SLL overflows when shifting the signed result back does not restore the operand.
   function automatic logic ref_ovf(logic [63:0] d, int unsigned s, logic [1:0] op, int unsigned w);
      if (op != 2'd0) return 1'b0;
      return (sext(ref_shift(d, s, op, w), w) >>> s) != sext(d, w);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] op, input logic [4:0] tag);
      bit ok = 1'b0;
      in_data  = d;
      in_shamt = s;
      in_op    = op;
      in_tag   = tag;
      in_valid = 1'b1;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clock);
         ok = (in_ready === 1'b1);
         @(posedge clock);
         #1;
      end
      total++;
      assert (ok) else begin
         bad++;
         $error("FAIL accept_timeout: got in_ready=0 want 1 (tag %0d)", tag);
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL drain: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic clear_logs();
      got_data.delete();
      got_tag.delete();
`ifdef SHIFTER_OVERFLOW_EN
      got_ovf.delete();
`endif
   endtask

   always @(posedge clock) cyc++;

   // Monitor: push on accept, pop and compare on consume, check hold during stalls.
   always @(negedge clock) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            assert (out_valid === 1'b1 && out_data === held_data && out_tag === held_tag) else begin
               bad++;
               $error("FAIL hold_stable: got v=%0b d=%h t=%0d want v=1 d=%h t=%0d",
                      out_valid, out_data, out_tag, held_data, held_tag);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_data.push_back(out_data);
            got_tag.push_back(out_tag);
`ifdef SHIFTER_OVERFLOW_EN
            got_ovf.push_back(out_ovf);
`endif
            total++;
            assert (sb.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_result: got d=%h t=%0d want no result", out_data, out_tag);
            end
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               total++;
               assert (out_data === mon_e.data && out_tag === mon_e.tag) else begin
                  bad++;
                  $error("FAIL result: got d=%h t=%0d want d=%h t=%0d", out_data, out_tag, mon_e.data, mon_e.tag);
               end
`ifdef SHIFTER_OVERFLOW_EN
               total++;
               assert (out_ovf === mon_e.ovf) else begin
                  bad++;
                  $error("FAIL ovf: got %0b want %0b (d=%h)", out_ovf, mon_e.ovf, mon_e.data);
               end
`endif
               if (lat_check) begin
                  total++;
                  assert (cyc - mon_e.cyc == L) else begin
                     bad++;
                     $error("FAIL latency: got %0d want %0d", cyc - mon_e.cyc, L);
                  end
               end
            end
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            mon_e.data = 32'(ref_shift({32'h0, in_data}, in_shamt, in_op, 32));
            mon_e.tag  = in_tag;
`ifdef SHIFTER_OVERFLOW_EN
            mon_e.ovf  = ref_ovf({32'h0, in_data}, in_shamt, in_op, 32);
`endif
            mon_e.cyc  = cyc;
            sb.push_back(mon_e);
         end
         prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
         held_data  = out_data;
         held_tag   = out_tag;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
      r8_in_valid = 1'b0; r8_in_data = '0; r8_in_shamt = '0; r8_in_op = '0; r8_in_tag = '0; r8_out_ready = 1'b1;

      // Reset state
      tick(2);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_tag", 64'(out_tag), 64'd0);
`ifdef SHIFTER_OVERFLOW_EN
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
      reset_n = 1'b1;
      #1;
      chk("in_ready_after_rst", 64'(in_ready), 64'd1);

      // Basic ops, back to back
      clear_logs();
      lat_check = 1'b1;
      for (int i = 0; i < 4; i++) send(32'h8000_00F1, 5'd4, 2'(i), 5'd7);
      drain();
      chk("basic_count", 64'(got_data.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("basic_data%0d", i), 64'(got_data[i]), 64'(exp1[i]));
         chk($sformatf("basic_tag%0d", i), 64'(got_tag[i]), 64'd7);
      end

      // Zero and maximum shifts
      clear_logs();
      for (int i = 0; i < 4; i++) send(32'hDEAD_BEEF, 5'd0, 2'(i), 5'(i));
      send(32'h8000_0000, 5'd31, 2'd2, 5'd4);
      send(32'h0000_0003, 5'd31, 2'd0, 5'd5);
      send(32'h8000_0001, 5'd31, 2'd3, 5'd6);
`ifdef SHIFTER_OVERFLOW_EN
      send(32'h4000_0000, 5'd1, 2'd0, 5'd8);
      send(32'h0000_0001, 5'd1, 2'd0, 5'd9);
`endif
      drain();
      for (int i = 0; i < 7; i++) chk($sformatf("edge_data%0d", i), 64'(got_data[i]), 64'(exp2[i]));
`ifdef SHIFTER_OVERFLOW_EN
      chk("ovf_sll_4000", 64'(got_ovf[7]), 64'd1);
      chk("ovf_sll_0001", 64'(got_ovf[8]), 64'd0);
`endif
      lat_check = 1'b0;

      // Backpressure while the pipe fills
      clear_logs();
      saw_low = 1'b0;
      fork
         begin
            for (int t = 1; t <= 5; t++) send(32'h1234_5678 ^ 32'(t), 5'(t), 2'(t % 4), 5'(t));
            in_valid = 1'b0;
         end
         begin
            tick(2);
            out_ready = 1'b0;
            repeat (4) begin
               @(negedge clock);
               if (in_ready === 1'b0) saw_low = 1'b1;
               @(posedge clock);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_in_ready_dropped", 64'(saw_low), 64'd1);
      chk("bp_count", 64'(got_tag.size()), 64'd5);
      for (int i = 0; i < 5; i++) chk($sformatf("bp_tag%0d", i), 64'(got_tag[i]), 64'(i + 1));

      // Bubbles: valid pattern reappears L cycles later
      for (int c = 0; c < 9; c++) begin
         in_valid = (c < 6) && (c % 2 == 0);
         in_data  = 32'hA5A5_0000 | 32'(c);
         in_shamt = 5'(c * 3);
         in_op    = 2'(c);
         in_tag   = 5'(c);
         @(negedge clock);
         ov[c] = (out_valid === 1'b1);
         @(posedge clock);
         #1;
      end
      drain();
      for (int c = 0; c < 9; c++)
         chk($sformatf("bubble_c%0d", c), 64'(ov[c]), 64'((c >= L) && ((c - L) % 2 == 0)));

      // Asynchronous reset with ops in flight
      send(32'h0F0F_0F0F, 5'd3, 2'd1, 5'd10);
      send(32'hF0F0_F0F0, 5'd5, 2'd2, 5'd11);
      send(32'h1357_9BDF, 5'd7, 2'd3, 5'd12);
      in_valid = 1'b0;
      chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_out_data", 64'(out_data), 64'd0);
      chk("async_rst_out_tag", 64'(out_tag), 64'd0);
      sb.delete();
      tick(2);
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         chk($sformatf("no_stale_c%0d", i), 64'(out_valid), 64'd0);
      end
      tick(1);

      // Random traffic with random backpressure
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               if ($urandom_range(0, 4) == 0) begin
                  in_valid = 1'b0;
                  tick(1);
               end
               send($urandom, 5'($urandom), 2'($urandom), 5'($urandom));
            end
            in_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               tick(1);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // 8-bit instance, one mux level per stage
      for (int i = 0; i < 5; i++) begin
         r8_in_data  = d8[i];
         r8_in_shamt = s8[i];
         r8_in_op    = o8[i];
         r8_in_tag   = 5'(i);
         r8_in_valid = 1'b1;
         chk($sformatf("w8_in_ready%0d", i), 64'(r8_in_ready), 64'd1);
         @(posedge clock);
         #1;
         r8_in_valid = 1'b0;
         @(negedge clock);
         @(negedge clock);
         chk($sformatf("w8_early%0d", i), 64'(r8_out_valid), 64'd0);
         @(negedge clock);
         chk($sformatf("w8_valid%0d", i), 64'(r8_out_valid), 64'd1);
         chk($sformatf("w8_data%0d", i), 64'(r8_out_data), 64'(x8[i]));
         chk($sformatf("w8_tag%0d", i), 64'(r8_out_tag), 64'(i));
`ifdef SHIFTER_OVERFLOW_EN
         chk($sformatf("w8_ovf%0d", i), 64'(r8_out_ovf), 64'(ref_ovf({56'h0, d8[i]}, s8[i], o8[i], 8)));
`endif
         @(posedge clock);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the combinational 32-bit left shifter used by the ALU.
- Performs SLL, SRL, SRA or ROR on a WIDTH-bit operand using log2(WIDTH) mux levels, with pipeline registers inserted every REG_EVERY levels.
- Carries a destination tag alongside each result.
- Uses a valid/ready handshake so the execute stage can stall it.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- REG_EVERY, 2, number of mux levels between pipeline registers; 1..log2(WIDTH).
- TAG_W, 5, width of passthrough tag (destination register index).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  shifter can accept an operation this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  log2(WIDTH)  shift amount, unsigned.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of out_data.

Behaviour:
- Levels and latency:
  - LEVELS = log2(WIDTH). Level k shifts by 2^(LEVELS-1-k), largest first, if shamt bit (LEVELS-1-k) is set.
  - A register bank follows every REG_EVERY levels, and always after the last level.
  - Latency L = ceil(LEVELS/REG_EVERY) cycles. Defaults: 5 levels, L = 3.
- What each register bank holds: partial data, remaining shamt bits, op, tag, valid.
- Fill per op:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with in_data[WIDTH-1], captured at input and carried down the pipe.
  - ROR: bits shifted out at the bottom re-enter at the top.
- shamt = 0 passes the operand unchanged for every op.
- Handshake:
  - advance = out_ready | ~out_valid.
  - in_ready = advance, combinational.
  - All stage registers load only when advance = 1. Otherwise every stage holds, including its valid bit.
  - An op is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
- Bubbles:
  - When advance = 1 and in_valid = 0, stage 0 loads valid = 0.
  - A bubble only needs its valid bit cleared; its data contents are don't-care internally.
  - Interior bubbles compress only through advance; no per-stage skid.
- Output stability: while out_valid = 1 and out_ready = 0, out_data, out_tag and out_valid must not change.
- Throughput: one op per cycle when out_ready is held high.
- Reset (reset_n = 0, any time, including mid-operation):
  - All valid bits clear immediately; out_valid = 0.
  - out_data = 0, out_tag = 0. Internal data registers also clear.
  - In-flight ops are discarded.
  - After deassertion, in_ready = 1 on the first cycle.
- Boundary conditions:
  - Simultaneous consume at the output and accept at the input is legal and required.
  - Stall while the pipe is full holds all L entries; no loss and no duplication.
  - ROR by WIDTH-1 equals rotate left by 1.

Optional Feature:
- Macro: SHIFTER_OVERFLOW_EN.
- When defined:
  - Adds output port out_ovf (1 bit), reset 0, aligned with out_data.
  - For SLL, out_ovf = 1 if any bit shifted out, or the final sign bit, differs from the original sign bit. This is signed-overflow detection for SLL-as-multiply.
  - Accumulated per level and carried in the stage registers.
  - Forced 0 for SRL, SRA and ROR.
- When undefined: the port and its logic do not exist; behaviour is otherwise identical.

Test Plan:
- Basic ops, WIDTH = 32, REG_EVERY = 2, out_ready = 1:
  - Stimulus: in_data = 0x8000_00F1, tag = 7, ops SLL/SRL/SRA/ROR with shamt = 4, issued back to back.
  - Response: out_data = 0x0000_0F10, 0x0800_000F, 0xF800_000F, 0x1800_000F, on cycles 3, 4, 5, 6 after the first accept; out_tag = 7 each time.
- Zero and maximum shift:
  - Stimulus: shamt = 0 on 0xDEAD_BEEF, then SRA by 31 on 0x8000_0000, then SLL by 31 on 0x0000_0003.
  - Response: 0xDEAD_BEEF, 0xFFFF_FFFF, 0x8000_0000.
- Backpressure:
  - Stimulus: issue 5 consecutive ops with tags 1..5; hold out_ready = 0 from cycle 3 for 4 cycles.
  - Response: in_ready drops while the pipe is full; out_data holds stable; tags 1..5 emerge in order, none lost or duplicated.
- Bubbles:
  - Stimulus: alternate in_valid 1/0 for 6 cycles.
  - Response: out_valid pattern is 1,0,1,0,1,0 delayed by L = 3 cycles.
- Reset mid-flight:
  - Stimulus: pull reset_n low asynchronously with 3 ops in flight.
  - Response: out_valid = 0, out_data = 0 without waiting for a clock edge; no stale result appears after release.
- Alternate parameters:
  - Stimulus: WIDTH = 8, REG_EVERY = 1, ROR 0x81 by 1.
  - Response: out_data = 0xC0 after L = 3 cycles.
  - With SHIFTER_OVERFLOW_EN defined, WIDTH = 32: SLL 0x4000_0000 by 1 gives out_ovf = 1; SLL 0x0000_0001 by 1 gives out_ovf = 0.
